// File: rtl/rv32_fetch_queue.sv
// rv32_fetch_queue: instruction-fetch stage of the RV32I pipeline.
// Owns the fetch PC, reads the (combinational) instruction memory, and
// buffers {PC, instruction} pairs in a small circular FIFO that feeds
// decode through a valid/ready handshake. An execute-stage redirect
// flushes the FIFO and restarts fetch at the (word-aligned) target.
module rv32_fetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [31:0]              io_imem_PC,
    input  logic [31:0]              io_imem_instr,
    input  logic                     io_redirect_valid,
    input  logic [31:0]              io_redirect_PC,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [31:0]              io_out_instr,
    output logic [31:0]              io_out_PC,
    output logic [$clog2(DEPTH):0]   io_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];

    // Next-state and handshake signals
    logic [31:0]   fetch_pc_s;
    logic [PW-1:0] rd_ptr_s;
    logic [PW-1:0] wr_ptr_s;
    logic [CW-1:0] count_s;
    logic          out_valid_s;
    logic          pop_s;
    logic          push_s;
    logic [31:0]   head_instr_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   redirect_target_s;
    logic          unused_redirect_offset_s;

    // The low two bits of a redirect target are meaningless for RV32I fetch.
    assign redirect_target_s        = {io_redirect_PC[31:2], 2'b00};
    assign unused_redirect_offset_s = ^io_redirect_PC[1:0];

    // Handshake: a redirect hides the head and blocks both push and pop.
    // Push-while-full is allowed only when the head leaves in the same cycle.
    always_comb begin
        out_valid_s = 1'b0;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        if (io_redirect_valid) begin
            out_valid_s = 1'b0;
            pop_s       = 1'b0;
            push_s      = 1'b0;
        end else begin
            out_valid_s = (count_r != CNT_ZERO);
            pop_s       = out_valid_s & io_out_ready;
            push_s      = (count_r < CNT_FULL) | pop_s;
        end
    end

    // Next-state for fetch PC, pointers and occupancy; redirect wins over all.
    always_comb begin
        fetch_pc_s = fetch_pc_r;
        rd_ptr_s   = rd_ptr_r;
        wr_ptr_s   = wr_ptr_r;
        count_s    = count_r;
        if (io_redirect_valid) begin
            fetch_pc_s = redirect_target_s;
            rd_ptr_s   = PTR_ZERO;
            wr_ptr_s   = PTR_ZERO;
            count_s    = CNT_ZERO;
        end else begin
            if (push_s) begin
                fetch_pc_s = fetch_pc_r + 32'd4;
                wr_ptr_s   = wr_ptr_r + PTR_ONE;
            end else begin
                fetch_pc_s = fetch_pc_r;
                wr_ptr_s   = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            count_s = count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control-state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
        end else begin
            fetch_pc_r <= fetch_pc_s;
            rd_ptr_r   <= rd_ptr_s;
            wr_ptr_r   <= wr_ptr_s;
            count_r    <= count_s;
        end
    end

    // FIFO storage: capture the fetched pair at the write pointer on push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= NOP_INSTR;
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
            instr_mem_r[wr_ptr_r] <= io_imem_instr;
        end else begin
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
        end
    end

    // Head presentation: stored entry when occupied, a NOP bubble otherwise.
    always_comb begin
        head_instr_s = NOP_INSTR;
        head_pc_s    = 32'h0000_0000;
        if (count_r != CNT_ZERO) begin
            head_instr_s = instr_mem_r[rd_ptr_r];
            head_pc_s    = pc_mem_r[rd_ptr_r];
        end else begin
            head_instr_s = NOP_INSTR;
            head_pc_s    = 32'h0000_0000;
        end
    end

    assign io_imem_PC   = fetch_pc_r;
    assign io_out_valid = out_valid_s;
    assign io_out_instr = head_instr_s;
    assign io_out_PC    = head_pc_s;
    assign io_count     = count_r;

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Self-checking bench for rv32_fetch_queue: a queue-based reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_rv32_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] acc[$];

    // Instruction memory: the word at byte address 4k holds the value k.
    assign imem_instr = imem_pc >> 2;

    rv32_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_imem_PC       (imem_pc),
        .io_imem_instr    (imem_instr),
        .io_redirect_valid(redirect_valid),
        .io_redirect_PC   (redirect_pc),
        .io_out_valid     (out_valid),
        .io_out_ready     (out_ready),
        .io_out_instr     (out_instr),
        .io_out_PC        (out_pc),
        .io_count         (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reference model: the FIFO as a queue of {pc, instr}, updated per edge.
    initial begin
        bit m_pop;
        bit m_push;
        ent_t e;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                mq.delete();
                m_fetch = RESET_PC;
            end else if (redirect_valid) begin
                mq.delete();
                m_fetch = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                m_pop  = (mq.size() != 0) && out_ready;
                m_push = (mq.size() < DEPTH) || m_pop;
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    e.pc    = m_fetch;
                    e.instr = m_fetch >> 2;
                    mq.push_back(e);
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison against the model; also logs DUT-accepted PCs.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        forever begin
            @(negedge clock);
            if (!reset && chk_en) begin
                exp_valid = (mq.size() != 0) && !redirect_valid;
                if (mq.size() != 0) begin
                    exp_pc    = mq[0].pc;
                    exp_instr = mq[0].instr;
                end else begin
                    exp_pc    = 32'h0;
                    exp_instr = NOP;
                end
                check("m_valid", {31'b0, out_valid}, {31'b0, exp_valid});
                check("m_pc", out_pc, exp_pc);
                check("m_instr", out_instr, exp_instr);
                check("m_count", {29'b0, count}, mq.size());
                check("m_imem_pc", imem_pc, m_fetch);
                if (out_valid && out_ready) acc.push_back(out_pc);
            end
        end
    end

    initial begin
        logic [31:0] a;
        #1 reset = 1'b1;
        tick(2);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'h0000_0013);
        check("rst_pc", out_pc, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_imem", imem_pc, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Fill with ready low
        tick(4);
        check("fill_count", {29'b0, count}, 32'd4);
        check("fill_imem", imem_pc, 32'h10);
        check("fill_head_pc", out_pc, 32'd0);
        check("fill_head_instr", out_instr, 32'd0);
        tick(1);
        check("full_hold_imem", imem_pc, 32'h10);
        check("full_hold_count", {29'b0, count}, 32'd4);

        // Stream from full
        out_ready = 1'b1;
        acc.delete();
        tick(8);
        out_ready = 1'b0;
        check("stream_len", acc.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            a = (i < acc.size()) ? acc[i] : 32'hDEAD_BEEF;
            check("stream_pc", a, 32'(4 * i));
        end
        check("stream_count", {29'b0, count}, 32'd4);
        check("stream_imem", imem_pc, 32'h30);

        // Redirect while full with ready high
        acc.delete();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check("rdf_valid_low", {31'b0, out_valid}, 32'd0);
        tick(1);
        check("rdf_count", {29'b0, count}, 32'd0);
        check("rdf_imem", imem_pc, 32'h200);
        check("rdf_no_accept", acc.size(), 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick(1);
        check("rdf_head_valid", {31'b0, out_valid}, 32'd1);
        check("rdf_head_pc", out_pc, 32'h200);
        tick(2);
        check("three_count", {29'b0, count}, 32'd3);
        check("three_imem", imem_pc, 32'h20C);

        // Redirect with three entries, unaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check("rd3_valid_low", {31'b0, out_valid}, 32'd0);
        tick(1);
        check("rd3_count", {29'b0, count}, 32'd0);
        check("rd3_imem", imem_pc, 32'h100);
        redirect_valid = 1'b0;
        tick(1);
        check("rd3_head_valid", {31'b0, out_valid}, 32'd1);
        check("rd3_head_pc", out_pc, 32'h100);
        check("rd3_head_instr", out_instr, 32'h40);

        // Redirect near the top of the address space: PC wrap
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick(1);
        check("wrap_imem", imem_pc, 32'hFFFF_FFF8);
        redirect_valid = 1'b0;
        acc.delete();
        tick(4);
        out_ready = 1'b0;
        check("wrap_len", acc.size(), 32'd3);
        a = (acc.size() > 0) ? acc[0] : 32'hDEAD_BEEF;
        check("wrap_pc0", a, 32'hFFFF_FFF8);
        a = (acc.size() > 1) ? acc[1] : 32'hDEAD_BEEF;
        check("wrap_pc1", a, 32'hFFFF_FFFC);
        a = (acc.size() > 2) ? acc[2] : 32'hDEAD_BEEF;
        check("wrap_pc2", a, 32'h0000_0000);
        tick(1);
        check("pre_rst_count", {29'b0, count}, 32'd2);
        check("pre_rst_head", out_pc, 32'h4);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_instr", out_instr, 32'h0000_0013);
        check("arst_pc", out_pc, 32'd0);
        check("arst_count", {29'b0, count}, 32'd0);
        check("arst_imem", imem_pc, 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("resume_valid", {31'b0, out_valid}, 32'd1);
        check("resume_pc", out_pc, 32'd0);
        check("resume_count", {29'b0, count}, 32'd1);
        check("resume_imem", imem_pc, 32'h4);

        // Mixed traffic; the per-cycle model check covers it
        for (int i = 0; i < 24; i++) begin
            out_ready      = (i % 3) != 0;
            redirect_valid = (i == 13);
            redirect_pc    = 32'h0000_0402;
            tick(1);
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
